scariv_dcache_bank_arb: RTL and testbench

SCARIV_DCACHE_BANK_ARB -- requirements
Module: scariv_dcache_bank_arb

---
 rtl/scariv_dcache_bank_arb.sv | 137 +++++++++++++
 tb/tb_scariv_dcache_bank_arb.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scariv_dcache_bank_arb.sv
// D-cache bank arbiter: routes LSU pipe and refill requests to the bank selected by
// their physical address and registers one winner per bank.
// Latency: grant (o_req_ready) is combinational; the granted request reaches the bank one cycle later.
// Backpressure: a busy bank grants nothing; losing requesters hold their request and retry.
// Ports:
//   i_clk, i_reset                          clock, async active-high reset
//   i_req_valid/i_req_paddr/o_req_ready     per-requester handshake (ids 0..LSU_NUM-1 LSU, LSU_NUM refill)
//   i_bank_busy                             per-bank stall
//   o_bank_valid/o_bank_req_id/o_bank_paddr registered per-bank request
//   i_perf_clear/o_conflict_cnt             saturating conflict-cycle counter and its clear
module scariv_dcache_bank_arb #(
  parameter int LSU_NUM   = 2,
  parameter int BANKS     = 4,
  parameter int PADDR_W   = 56,
  parameter int BANK_LSB  = 6,
  parameter int STARVE_TH = 7
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset,
  input  logic [LSU_NUM:0]                          i_req_valid,
  input  logic [(LSU_NUM+1)*PADDR_W-1:0]            i_req_paddr,
  output logic [LSU_NUM:0]                          o_req_ready,
  input  logic [BANKS-1:0]                          i_bank_busy,
  input  logic                                      i_perf_clear,
  output logic [BANKS-1:0]                          o_bank_valid,
  output logic [BANKS*$clog2(LSU_NUM+1)-1:0]        o_bank_req_id,
  output logic [BANKS*PADDR_W-1:0]                  o_bank_paddr,
  output logic [15:0]                               o_conflict_cnt
);

  localparam int REQ_NUM = LSU_NUM + 1;
  localparam int IDW     = $clog2(REQ_NUM);
  localparam int BW      = $clog2(BANKS);
  localparam int RRW     = (LSU_NUM > 1) ? $clog2(LSU_NUM) : 1;
  localparam int SW      = $clog2(STARVE_TH + 1);

  logic [BW-1:0]      req_bank  [REQ_NUM];
  logic [PADDR_W-1:0] req_paddr [REQ_NUM];
  logic [RRW-1:0]     rr_ptr    [BANKS];
  logic [SW-1:0]      starve_cnt[LSU_NUM];
  logic [BANKS-1:0]   bank_gnt;
  logic [IDW-1:0]     bank_sel  [BANKS];
  logic [LSU_NUM:0]   ready;

  // Round-robin pick: first set bit of mask at or after ptr (wrapping). MSB of the
  // result flags that something was found, the low bits carry the index.
  function automatic logic [IDW:0] rr_pick(input logic [LSU_NUM-1:0] mask,
                                           input logic [RRW-1:0]     ptr);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    // Walk from the farthest candidate back to ptr so the nearest one wins.
    for (int k = LSU_NUM - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % LSU_NUM;
      if (mask[idx]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  for (genvar r = 0; r < REQ_NUM; r++) begin : g_req
    assign req_paddr[r] = i_req_paddr[r*PADDR_W +: PADDR_W];
    assign req_bank[r]  = i_req_paddr[r*PADDR_W + BANK_LSB +: BW];
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [LSU_NUM-1:0] lsu_hit;
    logic [LSU_NUM-1:0] starved_hit;
    logic               refill_hit;
    logic [IDW:0]       pick_starved;
    logic [IDW:0]       pick_normal;

    for (genvar i = 0; i < LSU_NUM; i++) begin : g_lsu
      assign lsu_hit[i]     = i_req_valid[i] && (req_bank[i] == BW'(b));
      assign starved_hit[i] = lsu_hit[i] && (starve_cnt[i] == SW'(STARVE_TH));
    end

    assign refill_hit   = i_req_valid[LSU_NUM] && (req_bank[LSU_NUM] == BW'(b));
    assign pick_starved = rr_pick(starved_hit, rr_ptr[b]);
    assign pick_normal  = rr_pick(lsu_hit, rr_ptr[b]);

    // Starved LSU beats refill, refill beats ordinary LSU traffic.
    assign bank_gnt[b] = !i_reset && !i_bank_busy[b] &&
                         (pick_starved[IDW] || refill_hit || pick_normal[IDW]);
    assign bank_sel[b] = pick_starved[IDW] ? pick_starved[IDW-1:0] :
                         refill_hit        ? IDW'(LSU_NUM)         :
                                             pick_normal[IDW-1:0];
  end

  // Each requester targets exactly one bank, so at most one bank can grant it.
  always_comb begin
    ready = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_gnt[b]) ready[bank_sel[b]] = 1'b1;
    end
  end

  assign o_req_ready = ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_bank_valid   <= '0;
      o_bank_req_id  <= '0;
      o_bank_paddr   <= '0;
      o_conflict_cnt <= '0;
      for (int b = 0; b < BANKS; b++) rr_ptr[b] <= '0;
      for (int i = 0; i < LSU_NUM; i++) starve_cnt[i] <= '0;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        o_bank_valid[b] <= bank_gnt[b];
        if (bank_gnt[b]) begin
          o_bank_req_id[b*IDW +: IDW]       <= bank_sel[b];
          o_bank_paddr[b*PADDR_W +: PADDR_W] <= req_paddr[bank_sel[b]];
          // Refill grants leave the LSU rotation untouched.
          if (int'(bank_sel[b]) < LSU_NUM) begin
            rr_ptr[b] <= (int'(bank_sel[b]) == LSU_NUM - 1) ? '0 : RRW'(bank_sel[b] + 1'b1);
          end
        end
      end

      // Counters keep running while a bank is busy: busy time counts as losing.
      for (int i = 0; i < LSU_NUM; i++) begin
        if (ready[i] || !i_req_valid[i]) begin
          starve_cnt[i] <= '0;
        end else if (starve_cnt[i] != SW'(STARVE_TH)) begin
          starve_cnt[i] <= starve_cnt[i] + 1'b1;
        end
      end

      if (i_perf_clear) begin
        o_conflict_cnt <= '0;
      end else if (|(i_req_valid & ~ready) && (o_conflict_cnt != 16'hFFFF)) begin
        o_conflict_cnt <= o_conflict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_scariv_dcache_bank_arb.sv
// Testbench for scariv_dcache_bank_arb: directed scenarios plus a randomized run,
// all checked against a behavioural model of the arbitration rules.
// Inputs change just after the falling edge; outputs are sampled away from the rising edge.
module tb_scariv_dcache_bank_arb;

  localparam int LSU_NUM   = 2;
  localparam int BANKS     = 4;
  localparam int PADDR_W   = 56;
  localparam int BANK_LSB  = 6;
  localparam int STARVE_TH = 7;
  localparam int REQ_NUM   = LSU_NUM + 1;
  localparam int IDW       = 2;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [REQ_NUM-1:0]         req_valid = '0;
  logic [REQ_NUM*PADDR_W-1:0] req_paddr = '0;
  logic [REQ_NUM-1:0]         req_ready;
  logic [BANKS-1:0]           bank_busy = '0;
  logic                       perf_clear = 1'b0;
  logic [BANKS-1:0]           bank_valid;
  logic [BANKS*IDW-1:0]       bank_req_id;
  logic [BANKS*PADDR_W-1:0]   bank_paddr;
  logic [15:0]                conflict_cnt;

  scariv_dcache_bank_arb #(
    .LSU_NUM(LSU_NUM), .BANKS(BANKS), .PADDR_W(PADDR_W),
    .BANK_LSB(BANK_LSB), .STARVE_TH(STARVE_TH)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .i_req_paddr(req_paddr), .o_req_ready(req_ready),
    .i_bank_busy(bank_busy), .i_perf_clear(perf_clear),
    .o_bank_valid(bank_valid), .o_bank_req_id(bank_req_id),
    .o_bank_paddr(bank_paddr), .o_conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int               m_rr [BANKS];
  int               m_st [LSU_NUM];
  int               m_cnt;
  bit               m_bv [BANKS];
  int               m_bid[BANKS];
  logic [PADDR_W-1:0] m_bpa[BANKS];
  logic [REQ_NUM-1:0] exp_ready;

  function automatic int bank_of(int r);
    logic [REQ_NUM*PADDR_W-1:0] p;
    p = req_paddr;
    return int'(p[r*PADDR_W + BANK_LSB +: 2]);
  endfunction

  function automatic logic [PADDR_W-1:0] addr_of(int r);
    logic [REQ_NUM*PADDR_W-1:0] p;
    p = req_paddr;
    return p[r*PADDR_W +: PADDR_W];
  endfunction

  task automatic set_addr(int r, logic [PADDR_W-1:0] a);
    req_paddr[r*PADDR_W +: PADDR_W] = a;
  endtask

  function automatic void model_reset();
    for (int b = 0; b < BANKS; b++) begin
      m_rr[b] = 0; m_bv[b] = 0; m_bid[b] = 0; m_bpa[b] = '0;
    end
    for (int i = 0; i < LSU_NUM; i++) m_st[i] = 0;
    m_cnt = 0;
  endfunction

  // Who wins each bank this cycle: starved LSUs in rotation order, then refill,
  // then any LSU in rotation order.
  function automatic void model_eval();
    int w;
    int i;
    exp_ready = '0;
    if (rst) return;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_busy[b]) continue;
      w = -1;
      for (int k = 0; k < LSU_NUM; k++) begin
        i = (m_rr[b] + k) % LSU_NUM;
        if (w < 0 && req_valid[i] && bank_of(i) == b && m_st[i] == STARVE_TH) w = i;
      end
      if (w < 0 && req_valid[LSU_NUM] && bank_of(LSU_NUM) == b) w = LSU_NUM;
      for (int k = 0; k < LSU_NUM; k++) begin
        i = (m_rr[b] + k) % LSU_NUM;
        if (w < 0 && req_valid[i] && bank_of(i) == b) w = i;
      end
      if (w >= 0) exp_ready[w] = 1'b1;
    end
  endfunction

  task automatic settle();
    #1 model_eval();
  endtask

  // One clock: model advances on the rising edge, returns at the next falling edge.
  task automatic tick();
    #1 model_eval();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        m_bv[b] = 0;
        for (int r = 0; r < REQ_NUM; r++) begin
          if (exp_ready[r] && bank_of(r) == b) begin
            m_bv[b] = 1; m_bid[b] = r; m_bpa[b] = addr_of(r);
            if (r < LSU_NUM) m_rr[b] = (r + 1) % LSU_NUM;
          end
        end
      end
      for (int i = 0; i < LSU_NUM; i++) begin
        if (exp_ready[i] || !req_valid[i]) m_st[i] = 0;
        else if (m_st[i] < STARVE_TH) m_st[i] = m_st[i] + 1;
      end
      if (perf_clear) m_cnt = 0;
      else if ((req_valid & ~exp_ready) != '0 && m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; bank_busy = '0; perf_clear = 1'b0;
    #2;
    model_reset();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    set_addr(0, 56'h000); set_addr(1, 56'h040); set_addr(2, 56'h080);
    req_valid = 3'b111;
    #2;
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    n_checks++; if (bank_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_bank_valid got=%b exp=0000", bank_valid); end
    n_checks++; if (bank_req_id !== 8'h00) begin n_fail++; $display("FAIL reset_bank_req_id got=%h exp=00", bank_req_id); end
    n_checks++; if (bank_paddr !== '0) begin n_fail++; $display("FAIL reset_bank_paddr got=%h exp=0", bank_paddr); end
    n_checks++; if (conflict_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_conflict_cnt got=%h exp=0", conflict_cnt); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Runs in the first cycle after reset release: three distinct banks all granted.
  task automatic test_distinct();
    settle();
    n_checks++; if (req_ready !== 3'b111) begin n_fail++; $display("FAIL distinct_ready got=%b exp=111", req_ready); end
    tick();
    n_checks++; if (bank_valid !== 4'b0111) begin n_fail++; $display("FAIL distinct_bank_valid got=%b exp=0111", bank_valid); end
    n_checks++; if (bank_req_id !== 8'h24) begin n_fail++; $display("FAIL distinct_ids got=%h exp=24", bank_req_id); end
    for (int b = 0; b < 3; b++) begin
      n_checks++;
      if (bank_paddr[b*PADDR_W +: PADDR_W] !== m_bpa[b]) begin
        n_fail++; $display("FAIL distinct_paddr bank%0d got=%h exp=%h", b, bank_paddr[b*PADDR_W +: PADDR_W], m_bpa[b]);
      end
    end
    req_valid = '0;
    tick();
    n_checks++; if (bank_valid !== 4'b0000) begin n_fail++; $display("FAIL idle_bank_valid got=%b exp=0000", bank_valid); end
    n_checks++; if (bank_req_id !== 8'h24) begin n_fail++; $display("FAIL idle_ids_hold got=%h exp=24", bank_req_id); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_d;
    do_reset();
    set_addr(0, 56'h040); set_addr(1, 56'h1040);
    req_valid = 3'b011;
    for (int c = 0; c < 3; c++) begin
      settle();
      exp_d = (c % 2 == 0) ? 3'b001 : 3'b010;
      n_checks++; if (req_ready !== exp_d) begin n_fail++; $display("FAIL rr_ready cycle%0d got=%b exp=%b", c, req_ready, exp_d); end
      tick();
      n_checks++; if (conflict_cnt !== 16'(c + 1)) begin n_fail++; $display("FAIL rr_conflict_cnt cycle%0d got=%0d exp=%0d", c, conflict_cnt, c + 1); end
    end
    req_valid = '0;
  endtask

  task automatic test_starvation();
    logic [2:0] exp_d;
    do_reset();
    set_addr(0, 56'h080); set_addr(2, 56'h1080);
    req_valid = 3'b101;
    for (int c = 1; c <= 9; c++) begin
      settle();
      exp_d = (c == 8) ? 3'b001 : 3'b100;
      n_checks++; if (req_ready !== exp_d) begin n_fail++; $display("FAIL starve_ready cycle%0d got=%b exp=%b", c, req_ready, exp_d); end
      tick();
      n_checks++;
      if (bank_req_id[5:4] !== ((c == 8) ? 2'd0 : 2'd2)) begin
        n_fail++; $display("FAIL starve_bank2_id cycle%0d got=%0d", c, bank_req_id[5:4]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_bank_busy();
    do_reset();
    set_addr(1, 56'h0C0);
    req_valid = 3'b010; bank_busy = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_checks++; if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL busy_ready cycle%0d got=%b exp=0", c, req_ready[1]); end
      tick();
      n_checks++; if (bank_valid[3] !== 1'b0) begin n_fail++; $display("FAIL busy_bank_valid cycle%0d got=%b exp=0", c, bank_valid[3]); end
    end
    bank_busy = '0;
    settle();
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL unbusy_ready got=%b exp=010", req_ready); end
    tick();
    n_checks++; if (bank_valid !== 4'b1000) begin n_fail++; $display("FAIL unbusy_bank_valid got=%b exp=1000", bank_valid); end
    n_checks++; if (bank_req_id[7:6] !== 2'd1) begin n_fail++; $display("FAIL unbusy_id got=%0d exp=1", bank_req_id[7:6]); end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [2:0]  granted;
    logic [63:0] t;
    do_reset();
    granted = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < REQ_NUM; r++) begin
        // A request still waiting must stay unchanged; otherwise roll a new one.
        if (!(req_valid[r] && !granted[r])) begin
          t = {$urandom, $urandom};
          if ($urandom_range(0, 1) == 1) t[BANK_LSB +: 2] = 2'($urandom_range(0, 1));
          set_addr(r, t[PADDR_W-1:0]);
          req_valid[r] = ($urandom_range(0, 9) < 7);
        end
      end
      bank_busy  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      perf_clear = ($urandom_range(0, 19) == 0);
      settle();
      n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready cycle%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
      granted = exp_ready;
      tick();
      for (int b = 0; b < BANKS; b++) begin
        n_checks++; if (bank_valid[b] !== m_bv[b]) begin n_fail++; $display("FAIL rand_bank_valid cycle%0d bank%0d got=%b exp=%b", cyc, b, bank_valid[b], m_bv[b]); end
        n_checks++; if (bank_req_id[b*IDW +: IDW] !== 2'(m_bid[b])) begin n_fail++; $display("FAIL rand_bank_id cycle%0d bank%0d got=%0d exp=%0d", cyc, b, bank_req_id[b*IDW +: IDW], m_bid[b]); end
        n_checks++; if (bank_paddr[b*PADDR_W +: PADDR_W] !== m_bpa[b]) begin n_fail++; $display("FAIL rand_bank_paddr cycle%0d bank%0d got=%h exp=%h", cyc, b, bank_paddr[b*PADDR_W +: PADDR_W], m_bpa[b]); end
      end
      n_checks++; if (conflict_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rand_conflict_cnt cycle%0d got=%0d exp=%0d", cyc, conflict_cnt, m_cnt); end
    end
    req_valid = '0; bank_busy = '0; perf_clear = 1'b0;
  endtask

  task automatic test_saturate_clear();
    do_reset();
    set_addr(0, 56'h040); set_addr(1, 56'h1040);
    req_valid = 3'b011;
    repeat (65535) tick();
    n_checks++; if (conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got=%h exp=ffff", conflict_cnt); end
    tick();
    n_checks++; if (conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", conflict_cnt); end
    perf_clear = 1'b1;
    tick();
    n_checks++; if (conflict_cnt !== 16'h0000) begin n_fail++; $display("FAIL perf_clear got=%h exp=0", conflict_cnt); end
    perf_clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick();
    tick();
    n_checks++; if (bank_valid[1] !== 1'b1) begin n_fail++; $display("FAIL premid_bank_valid got=%b exp=1", bank_valid[1]); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bank_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_bank_valid got=%b exp=0000", bank_valid); end
    n_checks++; if (bank_req_id !== 8'h00) begin n_fail++; $display("FAIL midrst_ids got=%h exp=00", bank_req_id); end
    n_checks++; if (bank_paddr !== '0) begin n_fail++; $display("FAIL midrst_paddr got=%h exp=0", bank_paddr); end
    n_checks++; if (conflict_cnt !== 16'h0) begin n_fail++; $display("FAIL midrst_cnt got=%h exp=0", conflict_cnt); end
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL midrst_ready got=%b exp=000", req_ready); end
    model_reset();
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    tick();
    n_checks++; if (bank_valid !== 4'b0000) begin n_fail++; $display("FAIL postrst_bank_valid got=%b exp=0000", bank_valid); end
    // Rotation pointers are back at zero, so LSU0 wins the shared bank.
    req_valid = 3'b011;
    settle();
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL postrst_rr got=%b exp=001", req_ready); end
    tick();
    n_checks++; if (bank_valid !== 4'b0010 || bank_req_id[3:2] !== 2'd0) begin n_fail++; $display("FAIL postrst_grant valid=%b id=%0d exp valid=0010 id=0", bank_valid, bank_req_id[3:2]); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_round_robin();
    test_starvation();
    test_bank_busy();
    test_random();
    test_saturate_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
